// File: rtl/cms_pix_28_dut_cfg_emu.sv
// DUT-side configuration shift-chain emulator: serial shift, shadow latch on load, framing status.
// Optional feature macro: CMS_PIX_28_CFG_EMU_PARITY_EN (registered XOR of the shadow register).
module cms_pix_28_dut_cfg_emu #(
   parameter int CFG_WIDTH   = 256,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 16
) (
   input  logic                 fw_clk,
   input  logic                 fw_rst,
   input  logic                 dut_reset_not,
   input  logic                 dut_config_clk,
   input  logic                 dut_config_in,
   input  logic                 dut_config_load,
   output logic                 dut_config_out,
   output logic [CFG_WIDTH-1:0] cfg_shadow,
   output logic                 cfg_load_pulse,
   output logic                 cfg_length_ok,
   output logic                 cfg_overflow,
   output logic [CNT_W-1:0]     cfg_bit_count,
   output logic [CNT_W-1:0]     cfg_load_count,
   output logic                 cfg_parity
);

   typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

   localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(CFG_WIDTH);

   // One chain carries all four inputs so they stay aligned: {load, in, clk, reset_not}
   logic [SYNC_STAGES-1:0][3:0] sync_q;
   logic                        clk_prev, load_prev;
   logic                        rst_ok, s_clk, s_in, s_load;
   logic                        shift_ev, load_ev;
   logic [CFG_WIDTH-1:0]        shreg;
   state_t                      state, state_n;

   assign rst_ok   = sync_q[SYNC_STAGES-1][0];
   assign s_clk    = sync_q[SYNC_STAGES-1][1];
   assign s_in     = sync_q[SYNC_STAGES-1][2];
   assign s_load   = sync_q[SYNC_STAGES-1][3];
   assign shift_ev = rst_ok & s_clk & ~clk_prev;
   assign load_ev  = rst_ok & s_load & ~load_prev;

   always_ff @(posedge fw_clk) begin
      if (fw_rst) begin
         sync_q    <= '0;
         clk_prev  <= 1'b0;
         load_prev <= 1'b0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0],
                       {dut_config_load, dut_config_in, dut_config_clk, dut_reset_not}};
         clk_prev  <= s_clk;
         load_prev <= s_load;
      end
   end

   always_ff @(posedge fw_clk) begin
      if (fw_rst) begin
         shreg          <= '0;
         cfg_shadow     <= '0;
         dut_config_out <= 1'b0;
         cfg_load_pulse <= 1'b0;
         cfg_length_ok  <= 1'b0;
         cfg_overflow   <= 1'b0;
         cfg_bit_count  <= '0;
         cfg_load_count <= '0;
      end else begin
         cfg_load_pulse <= load_ev;
         dut_config_out <= shreg[CFG_WIDTH-1];
         if (!rst_ok) begin
            // chip reset keeps the load counter so FW can see loads across chip resets
            shreg         <= '0;
            cfg_shadow    <= '0;
            cfg_length_ok <= 1'b0;
            cfg_overflow  <= 1'b0;
            cfg_bit_count <= '0;
         end else begin
            if (load_ev) begin
               cfg_shadow     <= shreg;
               cfg_length_ok  <= (cfg_bit_count == WIDTH_C) && !cfg_overflow;
               cfg_load_count <= cfg_load_count + 1'b1;
            end
            if (shift_ev)
               shreg <= {shreg[CFG_WIDTH-2:0], s_in};
            // a shift coinciding with a load starts the new frame at count 1
            if (load_ev) begin
               cfg_bit_count <= {{(CNT_W-1){1'b0}}, shift_ev};
               cfg_overflow  <= 1'b0;
            end else if (shift_ev) begin
               if (cfg_bit_count != '1)
                  cfg_bit_count <= cfg_bit_count + 1'b1;
               if (cfg_bit_count >= WIDTH_C)
                  cfg_overflow <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge fw_clk) begin
      if (fw_rst) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      if (!rst_ok) begin
         state_n = IDLE;
      end else begin
         case (state)
            IDLE:    if (load_ev) state_n = LOAD; else if (shift_ev) state_n = SHIFT;
            SHIFT:   if (load_ev) state_n = LOAD;
            LOAD:    if (load_ev) state_n = LOAD; else if (shift_ev) state_n = SHIFT;
                     else state_n = IDLE;
            default: state_n = IDLE;
         endcase
      end
   end

`ifdef CMS_PIX_28_CFG_EMU_PARITY_EN
   always_ff @(posedge fw_clk) begin
      if (fw_rst || !rst_ok) cfg_parity <= 1'b0;
      else if (cfg_load_pulse) cfg_parity <= ^cfg_shadow;
   end
`else
   assign cfg_parity = 1'b0;
`endif

endmodule

// File: tb/tb_cms_pix_28_dut_cfg_emu.sv
// Bench for cms_pix_28_dut_cfg_emu: frame table plus readback scoreboard and corner sequences.
module tb_cms_pix_28_dut_cfg_emu;
   localparam int W  = 256;
   localparam int SS = 2;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          rstn = 1'b0, cclk = 1'b0, cin = 1'b0, cload = 1'b0;
   logic          dut_config_out, cfg_load_pulse, cfg_length_ok, cfg_overflow, cfg_parity;
   logic [W-1:0]  cfg_shadow;
   logic [CW-1:0] cfg_bit_count, cfg_load_count;

   cms_pix_28_dut_cfg_emu #(.CFG_WIDTH(W), .SYNC_STAGES(SS), .CNT_W(CW)) dut (
      .fw_clk(clk), .fw_rst(rst), .dut_reset_not(rstn), .dut_config_clk(cclk),
      .dut_config_in(cin), .dut_config_load(cload), .dut_config_out(dut_config_out),
      .cfg_shadow(cfg_shadow), .cfg_load_pulse(cfg_load_pulse), .cfg_length_ok(cfg_length_ok),
      .cfg_overflow(cfg_overflow), .cfg_bit_count(cfg_bit_count),
      .cfg_load_count(cfg_load_count), .cfg_parity(cfg_parity));

   always #5 clk = ~clk;

   typedef struct { int n; int kind; logic ok; logic ovf; } frame_t;
   typedef struct { int due; logic b; } sb_t;

   frame_t       frames [8];
   sb_t          q [$];
   int           checks = 0, failures = 0;
   int           cyc = 0, pulses = 0, exp_loads = 0;
   logic [W-1:0] m_sh = '0, m_shadow = '0;
   logic [W-1:0] a5_pat;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Scoreboard: each shift's expected MSB must appear exactly SS+2 cycles after the raw edge
   always @(negedge clk) begin
      if (cfg_load_pulse) pulses++;
      if (q.size() > 0 && q[0].due <= cyc) begin
         sb_t e;
         e = q.pop_front();
         chk("readback_time", W'(cyc), W'(e.due));
         chk("readback_bit", W'(dut_config_out), W'(e.b));
      end
   end

   function automatic logic exp_par(input logic [W-1:0] s);
`ifdef CMS_PIX_28_CFG_EMU_PARITY_EN
      return ^s;
`else
      return 1'b0 & s[0];
`endif
   endfunction

   function automatic logic frame_bit(input int kind, input int i, input int n);
      logic [7:0] a5;
      a5 = 8'hA5;
      case (kind)
         0: return a5[7 - (i % 8)];
         1: return 1'b0;
         2: return 1'($urandom % 2);
         3: return 1'b1;
         default: return (i == n - 1);
      endcase
   endfunction

   task automatic shift_bit(input logic b, input logic with_load);
      @(posedge clk); #1;
      cin = b; cclk = 1'b1;
      if (with_load) begin
         cload = 1'b1; m_shadow = m_sh; exp_loads++;
      end
      m_sh = {m_sh[W-2:0], b};
      q.push_back('{cyc + SS + 2, m_sh[W-1]});
      repeat (3) @(posedge clk);
      #1 cclk = 1'b0; cload = 1'b0;
      repeat (3) @(posedge clk);
   endtask

   task automatic do_load();
      @(posedge clk); #1;
      cload = 1'b1; m_shadow = m_sh; exp_loads++;
      repeat (3) @(posedge clk);
      #1 cload = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int p0;
      frames[0] = '{256, 0, 1'b1, 1'b0};
      frames[1] = '{256, 1, 1'b1, 1'b0};
      frames[2] = '{259, 2, 1'b0, 1'b1};
      frames[3] = '{10,  2, 1'b0, 1'b0};
      frames[4] = '{0,   1, 1'b0, 1'b0};
      frames[5] = '{255, 2, 1'b0, 1'b0};
      frames[6] = '{256, 3, 1'b1, 1'b0};
      frames[7] = '{256, 4, 1'b1, 1'b0};
      a5_pat = {32{8'hA5}};

      // fw_rst with random inputs
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         {rstn, cclk, cin, cload} = 4'($urandom);
      end
      @(negedge clk);
      chk("rst_out", W'(dut_config_out), '0);
      chk("rst_shadow", cfg_shadow, '0);
      chk("rst_pulse", W'(cfg_load_pulse), '0);
      chk("rst_len_ok", W'(cfg_length_ok), '0);
      chk("rst_ovf", W'(cfg_overflow), '0);
      chk("rst_bitcnt", W'(cfg_bit_count), '0);
      chk("rst_loadcnt", W'(cfg_load_count), '0);
      chk("rst_parity", W'(cfg_parity), '0);
      @(posedge clk); #1;
      rst = 1'b0; rstn = 1'b1; cclk = 1'b0; cin = 1'b0; cload = 1'b0;
      repeat (SS + 3) @(posedge clk);

      // frame table
      for (int f = 0; f < 8; f++) begin
         for (int i = 0; i < frames[f].n; i++)
            shift_bit(frame_bit(frames[f].kind, i, frames[f].n), 1'b0);
         @(negedge clk);
         chk("pre_bitcnt", W'(cfg_bit_count), W'(frames[f].n));
         chk("pre_ovf", W'(cfg_overflow), W'(frames[f].ovf));
         p0 = pulses;
         do_load();
         chk("shadow", cfg_shadow, m_shadow);
         chk("len_ok", W'(cfg_length_ok), W'(frames[f].ok));
         chk("loadcnt", W'(cfg_load_count), W'(exp_loads));
         chk("post_bitcnt", W'(cfg_bit_count), '0);
         chk("post_ovf", W'(cfg_overflow), '0);
         chk("pulse_cycles", W'(pulses - p0), W'(1));
         chk("parity", W'(cfg_parity), W'(exp_par(m_shadow)));
         if (f == 0) begin
            chk("shadow_a5", cfg_shadow, a5_pat);
            chk("out_msb", W'(dut_config_out), W'(1'b1));
         end
         if (f == 6) chk("shadow_ones", cfg_shadow, '1);
         if (f == 7) chk("shadow_single", cfg_shadow, W'(1));
      end

      // mid-frame chip reset; shifts and loads while held are ignored
      for (int i = 0; i < 5; i++) shift_bit(1'b1, 1'b0);
      @(posedge clk); #1 rstn = 1'b0;
      repeat (SS + 4) @(posedge clk);
      #1 cclk = 1'b1; cload = 1'b1;
      repeat (3) @(posedge clk);
      #1 cclk = 1'b0; cload = 1'b0;
      p0 = pulses;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("crst_bitcnt", W'(cfg_bit_count), '0);
      chk("crst_shadow", cfg_shadow, '0);
      chk("crst_len_ok", W'(cfg_length_ok), '0);
      chk("crst_loadcnt", W'(cfg_load_count), W'(exp_loads));
      chk("crst_out", W'(dut_config_out), '0);
      chk("crst_parity", W'(cfg_parity), '0);
      chk("crst_nopulse", W'(pulses - p0), '0);
      m_sh = '0; m_shadow = '0;
      @(posedge clk); #1 rstn = 1'b1;
      repeat (SS + 3) @(posedge clk);

      // full frame, then clock edge and load edge together
      for (int i = 0; i < W; i++) shift_bit(1'($urandom % 2), 1'b0);
      p0 = pulses;
      shift_bit(1'b1, 1'b1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("sim_shadow", cfg_shadow, m_shadow);
      chk("sim_len_ok", W'(cfg_length_ok), W'(1));
      chk("sim_bitcnt", W'(cfg_bit_count), W'(1));
      chk("sim_loadcnt", W'(cfg_load_count), W'(exp_loads));
      chk("sim_pulse", W'(pulses - p0), W'(1));
      chk("sim_parity", W'(cfg_parity), W'(exp_par(m_shadow)));

      for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
      chk("sb_drained", W'(q.size()), '0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
